fir_ctrl_seq: RTL and testbench
===============================

# fir_ctrl_seq

Parametrised command sequencer for the CBADC digital estimator FIR datapath. It decodes the 3-bit estimator opcode set (SHIFT_H, SHIFT_S, CALCULATE_O, NOP, NUM_SHIFT, N_CHANGE, K_CHANGE) from a valid/ready command port and drives the coefficient-LUT write strobes. In streaming mode it accepts control-bit samples, applies a runtime downsample factor, and sequences a K-cycle tap accumulation per output. Channel count, tap depth, coefficient width and downsample range are parameters, not fixed constants.

## Interface
- NMAX, 8: maximum channels (control bits per sample).
- KMAX, 256: maximum taps.
- CW, 24: command data / coefficient width; must be ≥ $clog2(KMAX+1) and ≥ NMAX.
- HAW, 7: coefficient LUT address width.
- DSW, 8: downsample-factor width.
- clk_i  in  1  clock.
- rst_ni  in  1  reset; **one clock; reset is asynchronous and active-low.**
- cmd_valid_i / cmd_ready_o  in/out  1  command handshake; transfer when both are high on a rising edge.
- cmd_op_i  in  3  opcode (opcode_e encoding).
- cmd_addr_i  in  HAW  LUT address for SHIFT_H.
- cmd_data_i  in  CW  coefficient, control-bit word, or parameter value.
- s_valid_i / s_ready_o  in/out  1  streaming control-bit sample handshake.
- s_data_i  in  NMAX  streaming sample.
- h_we_o, h_addr_o[HAW], h_data_o[CW]  out  coefficient LUT write.
- s_shift_o, s_data_o[NMAX]  out  shift one sample into the datapath window.
- acc_clr_o, acc_en_o  out  accumulator clear/enable.
- tap_idx_o  out  $clog2(KMAX)  current tap.
- out_valid_o  out  1  one-cycle pulse when an accumulated output is ready.
- busy_o  out  1  high when not in IDLE.
- err_o  out  1  sticky error flag, cleared only by reset.
- n_cfg_o, k_cfg_o, ds_cfg_o  out  current configuration.

## Operation
- States: IDLE, STREAM, ADDING. Reset puts the block in IDLE with n_cfg=NMAX, k_cfg=KMAX, ds_cfg=1 and ds_cnt=0. All other outputs reset to 0.
- IDLE behaviour:
  - cmd_ready_o=1 and s_ready_o=0.
  - SHIFT_H: h_we_o pulses for one cycle with h_addr_o=cmd_addr_i and h_data_o=cmd_data_i.
  - SHIFT_S: s_shift_o pulses with s_data_o=cmd_data_i[NMAX-1:0] & channel mask.
  - NUM_SHIFT: loads ds_cfg; a value of 0 becomes 1 and sets err_o.
  - N_CHANGE: loads n_cfg, clamped to 1..NMAX; any clamp sets err_o.
  - K_CHANGE: loads k_cfg, clamped to 1..KMAX; any clamp sets err_o.
  - CALCULATE_O: clears ds_cnt and moves to STREAM.
  - NOP: no effect. Opcode 3'b111: no effect and sets err_o.
- Channel mask: bits at index ≥ n_cfg in s_data_o are forced to 0.
- STREAM behaviour:
  - s_ready_o=1 and cmd_ready_o=1.
  - Each accepted sample pulses s_shift_o with the masked data and increments ds_cnt.
  - If ds_cnt==ds_cfg-1 at accept, ds_cnt wraps to 0 and the state moves to ADDING.
  - NOP sets stop_pending. Any other opcode is consumed, ignored, and sets err_o.
- ADDING behaviour:
  - s_ready_o=0 and cmd_ready_o=0.
  - For i=0..k_cfg-1, one cycle each: tap_idx_o=i and acc_en_o=1. acc_clr_o=1 only on i=0.
  - The cycle after the last tap: out_valid_o=1. The state then returns to STREAM, or to IDLE if stop_pending was set (stop_pending is cleared).
- Simultaneous NOP and a downsample-completing sample in the same STREAM cycle: both are accepted. The accumulation completes and out_valid_o fires, then the block goes to IDLE.
- NOP in STREAM with no accumulation pending: IDLE on the next cycle; ds_cnt is discarded.
- Reset during ADDING aborts immediately; no out_valid_o is produced.

## Timing
- All strobes (h_we_o, s_shift_o, acc_*, out_valid_o) are registered and appear in the cycle after the accepting edge.
- Per-output sequence, with the completing sample accepted at edge t:
  - tap 0 (with acc_clr_o) at cycle t+1;
  - tap k_cfg-1 at t+k_cfg;
  - out_valid_o at t+k_cfg+1;
  - s_ready_o low during t+1..t+k_cfg and high again at t+k_cfg+1.
- Throughput: one output per ds_cfg accepted samples, plus k_cfg stall cycles.
- A configuration write takes effect from the command accepted in the next cycle.
- busy_o is registered and equals state≠IDLE.

## Test plan
- Reset, then read outputs: all strobes 0, n_cfg=8, k_cfg=256, ds_cfg=1, busy_o=0, err_o=0.
- SHIFT_H with addr=7'h2A, data=24'h00ABCD -> next cycle h_we_o=1, h_addr_o=2A, h_data_o=00ABCD; h_we_o=0 the following cycle.
- N_CHANGE 4, K_CHANGE 3, NUM_SHIFT 2, CALCULATE_O, then 4 back-to-back samples 8'hFF -> s_data_o=8'h0F. On the 2nd sample: tap_idx 0,1,2 with acc_clr_o on tap 0, and s_ready_o low for 3 cycles. out_valid_o=1 twice in total.
- K_CHANGE 0 and K_CHANGE 300 -> k_cfg=1 then 256, err_o=1 and sticky.
- In STREAM, NOP in the same cycle as the downsample-completing sample -> the full accumulation runs, one out_valid_o pulse, then busy_o=0.
- rst_ni asserted at tap 5 of k_cfg=10 -> outputs immediately 0, state IDLE, no out_valid_o after release.

Source files
------------

// File: rtl/fir_ctrl_seq_if.sv
// ----------------------------------------------------------------------------
// fir_ctrl_seq_if
// Command and streaming-sample handshake bundle for the FIR control sequencer.
//   cmd_valid_i / cmd_ready_o : command handshake
//   cmd_op_i[3]               : estimator opcode
//   cmd_addr_i[HAW]           : coefficient LUT address (SHIFT_H)
//   cmd_data_i[CW]            : coefficient, control-bit word or parameter value
//   s_valid_i / s_ready_o     : streaming control-bit sample handshake
//   s_data_i[NMAX]            : streaming sample
// master : the command/sample source; slave : the sequencer.
// ----------------------------------------------------------------------------
interface fir_ctrl_seq_if #(
   parameter int NMAX = 8,
   parameter int CW   = 24,
   parameter int HAW  = 7
);
   logic            cmd_valid_i;
   logic            cmd_ready_o;
   logic [2:0]      cmd_op_i;
   logic [HAW-1:0]  cmd_addr_i;
   logic [CW-1:0]   cmd_data_i;
   logic            s_valid_i;
   logic            s_ready_o;
   logic [NMAX-1:0] s_data_i;

   modport master (
      output cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_data_i, s_valid_i, s_data_i,
      input  cmd_ready_o, s_ready_o
   );

   modport slave (
      input  cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_data_i, s_valid_i, s_data_i,
      output cmd_ready_o, s_ready_o
   );
endinterface

// File: rtl/fir_ctrl_seq.sv
// ----------------------------------------------------------------------------
// fir_ctrl_seq
// Command sequencer for the CBADC digital estimator FIR datapath. Decodes the
// estimator opcodes, drives coefficient-LUT writes, and in streaming mode
// downsamples incoming control-bit samples and sequences a k_cfg-cycle tap
// accumulation per output.
// Ports:
//   clk_i, rst_ni           : clock, asynchronous active-low reset
//   bus (slave)             : command and sample handshakes
//   h_we_o/h_addr_o/h_data_o: coefficient LUT write
//   s_shift_o/s_data_o      : shift one masked sample into the datapath window
//   acc_clr_o/acc_en_o      : accumulator clear/enable
//   tap_idx_o               : current tap during accumulation
//   out_valid_o             : one-cycle pulse when an output is complete
//   busy_o                  : sequencer not idle
//   err_o                   : sticky error flag
//   n_cfg_o/k_cfg_o/ds_cfg_o: active channel count, tap count, downsample factor
// ----------------------------------------------------------------------------
module fir_ctrl_seq #(
   parameter int NMAX = 8,
   parameter int KMAX = 256,
   parameter int CW   = 24,
   parameter int HAW  = 7,
   parameter int DSW  = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   fir_ctrl_seq_if.slave              bus,
   output logic                       h_we_o,
   output logic [HAW-1:0]             h_addr_o,
   output logic [CW-1:0]              h_data_o,
   output logic                       s_shift_o,
   output logic [NMAX-1:0]            s_data_o,
   output logic                       acc_clr_o,
   output logic                       acc_en_o,
   output logic [$clog2(KMAX)-1:0]    tap_idx_o,
   output logic                       out_valid_o,
   output logic                       busy_o,
   output logic                       err_o,
   output logic [$clog2(NMAX+1)-1:0]  n_cfg_o,
   output logic [$clog2(KMAX+1)-1:0]  k_cfg_o,
   output logic [DSW-1:0]             ds_cfg_o
);

   localparam int TW = $clog2(KMAX);
   localparam int NW = $clog2(NMAX+1);
   localparam int KW = $clog2(KMAX+1);

   typedef enum logic [1:0] {IDLE, STREAM, ADDING} state_e;

   typedef enum logic [2:0] {
      OP_SHIFT_H     = 3'd0,
      OP_SHIFT_S     = 3'd1,
      OP_CALCULATE_O = 3'd2,
      OP_NOP         = 3'd3,
      OP_NUM_SHIFT   = 3'd4,
      OP_N_CHANGE    = 3'd5,
      OP_K_CHANGE    = 3'd6,
      OP_INVALID     = 3'd7
   } opcode_e;

   // Saturate a configuration value into 1..hi.
   function automatic logic [CW-1:0] clamp_cfg(input logic [CW-1:0] v, input logic [CW-1:0] hi);
      if (v == '0)    return CW'(1);
      else if (v > hi) return hi;
      else            return v;
   endfunction

   function automatic logic cfg_err(input logic [CW-1:0] v, input logic [CW-1:0] hi);
      return (v == '0) || (v > hi);
   endfunction

   // Channels at index >= n are not populated and read as 0.
   function automatic logic [NMAX-1:0] chan_mask(input logic [NW-1:0] n);
      logic [NMAX-1:0] m;
      for (int i = 0; i < NMAX; i++) m[i] = (i < int'(n));
      return m;
   endfunction

   state_e            state_q, state_n;
   opcode_e           op;
   logic [NW-1:0]     n_cfg_n;
   logic [KW-1:0]     k_cfg_n;
   logic [DSW-1:0]    ds_cfg_n, ds_cnt_q, ds_cnt_n, ds_val;
   logic              stop_q, stop_n, err_n;
   logic              h_we_n, s_shift_n, acc_clr_n, acc_en_n, out_valid_n;
   logic [HAW-1:0]    h_addr_n;
   logic [CW-1:0]     h_data_n;
   logic [NMAX-1:0]   s_data_n;
   logic [TW-1:0]     tap_n;
   logic              cmd_ready, s_ready;

   assign op     = opcode_e'(bus.cmd_op_i);
   assign ds_val = bus.cmd_data_i[DSW-1:0];

   assign bus.cmd_ready_o = cmd_ready;
   assign bus.s_ready_o   = s_ready;

   always_comb begin
      state_n     = state_q;
      n_cfg_n     = n_cfg_o;
      k_cfg_n     = k_cfg_o;
      ds_cfg_n    = ds_cfg_o;
      ds_cnt_n    = ds_cnt_q;
      stop_n      = stop_q;
      err_n       = err_o;
      h_we_n      = 1'b0;
      h_addr_n    = h_addr_o;
      h_data_n    = h_data_o;
      s_shift_n   = 1'b0;
      s_data_n    = s_data_o;
      acc_clr_n   = 1'b0;
      acc_en_n    = 1'b0;
      tap_n       = '0;
      out_valid_n = 1'b0;
      cmd_ready   = 1'b0;
      s_ready     = 1'b0;

      case (state_q)
         IDLE: begin
            cmd_ready = 1'b1;
            if (bus.cmd_valid_i) begin
               case (op)
                  OP_SHIFT_H: begin
                     h_we_n   = 1'b1;
                     h_addr_n = bus.cmd_addr_i;
                     h_data_n = bus.cmd_data_i;
                  end
                  OP_SHIFT_S: begin
                     s_shift_n = 1'b1;
                     s_data_n  = bus.cmd_data_i[NMAX-1:0] & chan_mask(n_cfg_o);
                  end
                  OP_NUM_SHIFT: begin
                     if (ds_val == '0) begin
                        ds_cfg_n = DSW'(1);
                        err_n    = 1'b1;
                     end else begin
                        ds_cfg_n = ds_val;
                     end
                  end
                  OP_N_CHANGE: begin
                     n_cfg_n = NW'(clamp_cfg(bus.cmd_data_i, CW'(NMAX)));
                     if (cfg_err(bus.cmd_data_i, CW'(NMAX))) err_n = 1'b1;
                  end
                  OP_K_CHANGE: begin
                     k_cfg_n = KW'(clamp_cfg(bus.cmd_data_i, CW'(KMAX)));
                     if (cfg_err(bus.cmd_data_i, CW'(KMAX))) err_n = 1'b1;
                  end
                  OP_CALCULATE_O: begin
                     ds_cnt_n = '0;
                     state_n  = STREAM;
                  end
                  OP_NOP: ;
                  default: err_n = 1'b1;
               endcase
            end
         end

         STREAM: begin
            cmd_ready = 1'b1;
            s_ready   = 1'b1;
            if (bus.s_valid_i) begin
               s_shift_n = 1'b1;
               s_data_n  = bus.s_data_i & chan_mask(n_cfg_o);
               if (ds_cnt_q == ds_cfg_o - DSW'(1)) begin
                  ds_cnt_n  = '0;
                  state_n   = ADDING;
                  acc_en_n  = 1'b1;
                  acc_clr_n = 1'b1;
               end else begin
                  ds_cnt_n = ds_cnt_q + DSW'(1);
               end
            end
            // A stop request that coincides with a completing sample waits
            // for that accumulation to finish; otherwise it stops at once.
            if (bus.cmd_valid_i) begin
               if (op == OP_NOP) begin
                  if (state_n == ADDING) begin
                     stop_n = 1'b1;
                  end else begin
                     state_n  = IDLE;
                     ds_cnt_n = '0;
                  end
               end else begin
                  err_n = 1'b1;
               end
            end
         end

         ADDING: begin
            if (KW'(tap_idx_o) == k_cfg_o - KW'(1)) begin
               out_valid_n = 1'b1;
               stop_n      = 1'b0;
               state_n     = stop_q ? IDLE : STREAM;
            end else begin
               acc_en_n = 1'b1;
               tap_n    = tap_idx_o + TW'(1);
            end
         end

         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         n_cfg_o     <= NW'(NMAX);
         k_cfg_o     <= KW'(KMAX);
         ds_cfg_o    <= DSW'(1);
         ds_cnt_q    <= '0;
         stop_q      <= 1'b0;
         err_o       <= 1'b0;
         h_we_o      <= 1'b0;
         h_addr_o    <= '0;
         h_data_o    <= '0;
         s_shift_o   <= 1'b0;
         s_data_o    <= '0;
         acc_clr_o   <= 1'b0;
         acc_en_o    <= 1'b0;
         tap_idx_o   <= '0;
         out_valid_o <= 1'b0;
         busy_o      <= 1'b0;
      end else begin
         state_q     <= state_n;
         n_cfg_o     <= n_cfg_n;
         k_cfg_o     <= k_cfg_n;
         ds_cfg_o    <= ds_cfg_n;
         ds_cnt_q    <= ds_cnt_n;
         stop_q      <= stop_n;
         err_o       <= err_n;
         h_we_o      <= h_we_n;
         h_addr_o    <= h_addr_n;
         h_data_o    <= h_data_n;
         s_shift_o   <= s_shift_n;
         s_data_o    <= s_data_n;
         acc_clr_o   <= acc_clr_n;
         acc_en_o    <= acc_en_n;
         tap_idx_o   <= tap_n;
         out_valid_o <= out_valid_n;
         busy_o      <= (state_n != IDLE);
      end
   end

endmodule

// File: tb/tb_fir_ctrl_seq.sv
// ----------------------------------------------------------------------------
// tb_fir_ctrl_seq
// Directed bench for fir_ctrl_seq: reset state, LUT write, sample shift,
// configuration clamping, downsampled accumulation sequencing, stop handling
// and reset abort.
// ----------------------------------------------------------------------------
module tb_fir_ctrl_seq;

   localparam logic [2:0] OP_SHIFT_H     = 3'd0;
   localparam logic [2:0] OP_SHIFT_S     = 3'd1;
   localparam logic [2:0] OP_CALCULATE_O = 3'd2;
   localparam logic [2:0] OP_NOP         = 3'd3;
   localparam logic [2:0] OP_NUM_SHIFT   = 3'd4;
   localparam logic [2:0] OP_N_CHANGE    = 3'd5;
   localparam logic [2:0] OP_K_CHANGE    = 3'd6;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        h_we, s_shift, acc_clr, acc_en, out_valid, busy, err;
   logic [6:0]  h_addr;
   logic [23:0] h_data;
   logic [7:0]  s_data;
   logic [7:0]  tap_idx;
   logic [3:0]  n_cfg;
   logic [8:0]  k_cfg;
   logic [7:0]  ds_cfg;

   int checks = 0;
   int errors = 0;
   int ov_cnt;
   int low_cnt;
   int act_cnt;

   always #5 clk = ~clk;

   fir_ctrl_seq_if #(.NMAX(8), .CW(24), .HAW(7)) bus ();

   fir_ctrl_seq #(.NMAX(8), .KMAX(256), .CW(24), .HAW(7), .DSW(8)) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .bus        (bus.slave),
      .h_we_o     (h_we),
      .h_addr_o   (h_addr),
      .h_data_o   (h_data),
      .s_shift_o  (s_shift),
      .s_data_o   (s_data),
      .acc_clr_o  (acc_clr),
      .acc_en_o   (acc_en),
      .tap_idx_o  (tap_idx),
      .out_valid_o(out_valid),
      .busy_o     (busy),
      .err_o      (err),
      .n_cfg_o    (n_cfg),
      .k_cfg_o    (k_cfg),
      .ds_cfg_o   (ds_cfg)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [2:0] op, input logic [6:0] addr, input logic [23:0] data);
      bus.cmd_op_i    = op;
      bus.cmd_addr_i  = addr;
      bus.cmd_data_i  = data;
      bus.cmd_valid_i = 1'b1;
      tick();
      bus.cmd_valid_i = 1'b0;
   endtask

   initial begin
      rst_n           = 1'b0;
      bus.cmd_valid_i = 1'b0;
      bus.cmd_op_i    = 3'd0;
      bus.cmd_addr_i  = 7'd0;
      bus.cmd_data_i  = 24'd0;
      bus.s_valid_i   = 1'b0;
      bus.s_data_i    = 8'd0;

      // Reset state
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      chk("rst_h_we",      32'(h_we), 0);
      chk("rst_s_shift",   32'(s_shift), 0);
      chk("rst_acc_en",    32'(acc_en), 0);
      chk("rst_acc_clr",   32'(acc_clr), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_tap_idx",   32'(tap_idx), 0);
      chk("rst_n_cfg",     32'(n_cfg), 8);
      chk("rst_k_cfg",     32'(k_cfg), 256);
      chk("rst_ds_cfg",    32'(ds_cfg), 1);
      chk("rst_busy",      32'(busy), 0);
      chk("rst_err",       32'(err), 0);
      chk("rst_cmd_ready", 32'(bus.cmd_ready_o), 1);
      chk("rst_s_ready",   32'(bus.s_ready_o), 0);

      // Coefficient write
      send_cmd(OP_SHIFT_H, 7'h2A, 24'h00ABCD);
      chk("shh_we",   32'(h_we), 1);
      chk("shh_addr", 32'(h_addr), 32'h2A);
      chk("shh_data", 32'(h_data), 32'h00ABCD);
      tick();
      chk("shh_we_drop", 32'(h_we), 0);

      // Command-driven sample shift, all 8 channels active
      send_cmd(OP_SHIFT_S, 7'h0, 24'h0000A5);
      chk("shs_shift", 32'(s_shift), 1);
      chk("shs_data",  32'(s_data), 32'hA5);

      // Configuration
      send_cmd(OP_N_CHANGE, 7'h0, 24'd4);
      chk("cfg_n", 32'(n_cfg), 4);
      send_cmd(OP_K_CHANGE, 7'h0, 24'd3);
      chk("cfg_k", 32'(k_cfg), 3);
      send_cmd(OP_NUM_SHIFT, 7'h0, 24'd2);
      chk("cfg_ds", 32'(ds_cfg), 2);
      chk("cfg_err", 32'(err), 0);

      send_cmd(OP_CALCULATE_O, 7'h0, 24'd0);
      chk("calc_busy",      32'(busy), 1);
      chk("calc_s_ready",   32'(bus.s_ready_o), 1);
      chk("calc_cmd_ready", 32'(bus.cmd_ready_o), 1);

      // Four back-to-back samples, ds=2, k=3, 4 channels
      bus.s_data_i  = 8'hFF;
      bus.s_valid_i = 1'b1;
      tick();
      chk("s1_shift",  32'(s_shift), 1);
      chk("s1_data",   32'(s_data), 32'h0F);
      chk("s1_acc_en", 32'(acc_en), 0);
      tick();
      chk("s2_shift",     32'(s_shift), 1);
      chk("s2_acc_en",    32'(acc_en), 1);
      chk("s2_acc_clr",   32'(acc_clr), 1);
      chk("s2_tap",       32'(tap_idx), 0);
      chk("s2_s_ready",   32'(bus.s_ready_o), 0);
      chk("s2_cmd_ready", 32'(bus.cmd_ready_o), 0);
      tick();
      chk("t1_acc_en",  32'(acc_en), 1);
      chk("t1_acc_clr", 32'(acc_clr), 0);
      chk("t1_tap",     32'(tap_idx), 1);
      chk("t1_shift",   32'(s_shift), 0);
      chk("t1_s_ready", 32'(bus.s_ready_o), 0);
      tick();
      chk("t2_tap",     32'(tap_idx), 2);
      chk("t2_acc_en",  32'(acc_en), 1);
      chk("t2_s_ready", 32'(bus.s_ready_o), 0);
      tick();
      chk("ov1_out_valid", 32'(out_valid), 1);
      chk("ov1_acc_en",    32'(acc_en), 0);
      chk("ov1_s_ready",   32'(bus.s_ready_o), 1);
      ov_cnt = 1;
      tick();
      chk("s3_shift",     32'(s_shift), 1);
      chk("s3_out_valid", 32'(out_valid), 0);
      tick();
      bus.s_valid_i = 1'b0;
      chk("s4_acc_clr", 32'(acc_clr), 1);
      chk("s4_tap",     32'(tap_idx), 0);
      low_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         if (!bus.s_ready_o) low_cnt++;
         if (out_valid) ov_cnt++;
         tick();
      end
      chk("stall_cycles",    32'(low_cnt), 3);
      chk("out_valid_total", 32'(ov_cnt), 2);

      // NOP with nothing pending returns to IDLE
      send_cmd(OP_NOP, 7'h0, 24'd0);
      chk("nop_busy",    32'(busy), 0);
      chk("nop_s_ready", 32'(bus.s_ready_o), 0);
      chk("nop_err",     32'(err), 0);

      // Tap count clamping and sticky error
      send_cmd(OP_K_CHANGE, 7'h0, 24'd0);
      chk("k0_k_cfg", 32'(k_cfg), 1);
      chk("k0_err",   32'(err), 1);
      send_cmd(OP_K_CHANGE, 7'h0, 24'd300);
      chk("k300_k_cfg", 32'(k_cfg), 256);
      chk("k300_err",   32'(err), 1);
      send_cmd(OP_NOP, 7'h0, 24'd0);
      chk("err_sticky", 32'(err), 1);

      // NOP together with the downsample-completing sample
      send_cmd(OP_K_CHANGE, 7'h0, 24'd3);
      send_cmd(OP_CALCULATE_O, 7'h0, 24'd0);
      bus.s_data_i  = 8'h35;
      bus.s_valid_i = 1'b1;
      tick();
      chk("sn1_data", 32'(s_data), 32'h05);
      bus.s_data_i    = 8'hFF;
      bus.cmd_op_i    = OP_NOP;
      bus.cmd_valid_i = 1'b1;
      tick();
      bus.cmd_valid_i = 1'b0;
      bus.s_valid_i   = 1'b0;
      chk("sn_acc_en",  32'(acc_en), 1);
      chk("sn_acc_clr", 32'(acc_clr), 1);
      chk("sn_busy",    32'(busy), 1);
      tick();
      tick();
      chk("sn_tap2", 32'(tap_idx), 2);
      chk("sn_busy2", 32'(busy), 1);
      tick();
      chk("sn_out_valid", 32'(out_valid), 1);
      chk("sn_busy_end",  32'(busy), 0);
      chk("sn_cmd_ready", 32'(bus.cmd_ready_o), 1);
      chk("sn_s_ready",   32'(bus.s_ready_o), 0);
      tick();
      chk("sn_ov_drop", 32'(out_valid), 0);

      // Reset in the middle of a 10-tap accumulation
      send_cmd(OP_K_CHANGE, 7'h0, 24'd10);
      send_cmd(OP_NUM_SHIFT, 7'h0, 24'd1);
      send_cmd(OP_CALCULATE_O, 7'h0, 24'd0);
      bus.s_data_i  = 8'h01;
      bus.s_valid_i = 1'b1;
      tick();
      bus.s_valid_i = 1'b0;
      chk("ab_tap0", 32'(tap_idx), 0);
      repeat (5) tick();
      chk("ab_tap5",   32'(tap_idx), 5);
      chk("ab_acc_en", 32'(acc_en), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ab_acc_en_rst", 32'(acc_en), 0);
      chk("ab_tap_rst",    32'(tap_idx), 0);
      chk("ab_busy_rst",   32'(busy), 0);
      chk("ab_err_rst",    32'(err), 0);
      chk("ab_k_cfg_rst",  32'(k_cfg), 256);
      chk("ab_s_ready",    32'(bus.s_ready_o), 0);
      tick();
      rst_n   = 1'b1;
      act_cnt = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (out_valid || acc_en) act_cnt++;
      end
      chk("ab_no_output", 32'(act_cnt), 0);
      chk("ab_idle",      32'(busy), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
